// File: rtl/i2c_target_regfile_if.sv
// i2c_target_regfile_if: I2C pad and register-file fabric signals of the loopback target
interface i2c_target_regfile_if #(parameter int AW = 4);
   logic          scl_i;
   logic          sda_i;
   logic          sda_oe_o;
   logic          wr_valid_o;
   logic [AW-1:0] wr_addr_o;
   logic [7:0]    wr_data_o;
   logic [AW-1:0] rd_addr_i;
   logic [7:0]    rd_data_o;
   logic          busy_o;
   modport slave (
      input  scl_i, sda_i, rd_addr_i,
      output sda_oe_o, wr_valid_o, wr_addr_o, wr_data_o, rd_data_o, busy_o
   );
   modport master (
      output scl_i, sda_i, rd_addr_i,
      input  sda_oe_o, wr_valid_o, wr_addr_o, wr_data_o, rd_data_o, busy_o
   );
endinterface

// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile: oversampled I2C target with an EEPROM-style auto-incrementing register file
module i2c_target_regfile #(
   parameter logic [6:0] DevAddr   = 7'h50,
   parameter int         NumRegs   = 16,
   parameter int         FilterLen = 3
) (
   input logic                 clk_i,
   input logic                 rst_ni,
   i2c_target_regfile_if.slave bus
);
   localparam int AW = $clog2(NumRegs);
   localparam int CW = $clog2(FilterLen + 1);
   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_ACK, S_PTR, S_WDATA, S_RDATA, S_RACK} state_t;
   logic [1:0]          r_s1, r_s2, r_flt, r_prv;
   logic [1:0][CW-1:0]  r_cnt;
   state_t              r_state, r_after;
   logic [3:0]          r_bcnt;
   logic [7:0]          r_shift;
   logic [AW-1:0]       r_ptr, r_wr_addr;
   logic [7:0]          r_wr_data;
   logic                r_ack_drv, r_oe, r_busy, r_wr_valid;
   logic [7:0]          r_regs [NumRegs];
   logic                w_scl_rise, w_scl_fall, w_scl_hi, w_start, w_stop, w_sda, w_last;
   logic [7:0]          w_byte, w_rd_byte;
   // index 1 carries SCL, index 0 carries SDA
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         r_s1  <= '1;
         r_s2  <= '1;
         r_flt <= '1;
         r_prv <= '1;
         r_cnt <= '0;
      end else begin
         r_s1  <= {bus.scl_i, bus.sda_i};
         r_s2  <= r_s1;
         r_prv <= r_flt;
         for (int k = 0; k < 2; k++)
            if (r_s2[k] == r_flt[k]) r_cnt[k] <= '0;
            else if (r_cnt[k] == CW'(FilterLen - 1)) begin
               r_flt[k] <= r_s2[k];
               r_cnt[k] <= '0;
            end else r_cnt[k] <= r_cnt[k] + CW'(1);
      end
   assign w_sda      = r_flt[0];
   assign w_scl_rise = r_flt[1] & ~r_prv[1];
   assign w_scl_fall = ~r_flt[1] & r_prv[1];
   assign w_scl_hi   = r_flt[1] & r_prv[1];
   assign w_start    = w_scl_hi & r_prv[0] & ~r_flt[0];
   assign w_stop     = w_scl_hi & ~r_prv[0] & r_flt[0];
   assign w_byte     = {r_shift[6:0], w_sda};
   assign w_last     = r_bcnt == 4'd7;
   assign w_rd_byte  = r_regs[r_ptr];
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         r_state    <= S_IDLE;
         r_after    <= S_IDLE;
         r_bcnt     <= '0;
         r_shift    <= '0;
         r_ptr      <= '0;
         r_ack_drv  <= 1'b0;
         r_oe       <= 1'b0;
         r_busy     <= 1'b0;
         r_wr_valid <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         r_regs     <= '{default: '0};
      end else begin
         r_wr_valid <= 1'b0;
         if (w_stop) begin
            r_state <= S_IDLE;
            r_oe    <= 1'b0;
            r_busy  <= 1'b0;
         end else if (w_start) begin
            r_state <= S_ADDR;
            r_bcnt  <= '0;
            r_oe    <= 1'b0;
         end else case (r_state)
            S_ADDR, S_PTR, S_WDATA: if (w_scl_rise) begin
               r_shift <= w_byte;
               r_bcnt  <= r_bcnt + 4'd1;
               if (w_last) begin
                  r_bcnt    <= '0;
                  r_ack_drv <= 1'b0;
                  r_state   <= S_ACK;
                  if (r_state == S_ADDR) begin
                     if (w_byte[7:1] == DevAddr) begin
                        r_busy  <= 1'b1;
                        r_after <= w_byte[0] ? S_RDATA : S_PTR;
                     end else r_state <= S_IDLE;
                  end else if (r_state == S_PTR) begin
                     r_ptr   <= w_byte[AW-1:0];
                     r_after <= S_WDATA;
                  end else begin
                     r_regs[r_ptr] <= w_byte;
                     r_wr_valid    <= 1'b1;
                     r_wr_addr     <= r_ptr;
                     r_wr_data     <= w_byte;
                     r_ptr         <= r_ptr + AW'(1);
                     r_after       <= S_WDATA;
                  end
               end
            end
            // first fall asserts the ACK, second fall ends it (and starts a read byte)
            S_ACK: if (w_scl_fall) begin
               if (!r_ack_drv) begin
                  r_ack_drv <= 1'b1;
                  r_oe      <= 1'b1;
               end else if (r_after == S_RDATA) begin
                  r_shift <= w_rd_byte;
                  r_oe    <= ~w_rd_byte[7];
                  r_bcnt  <= '0;
                  r_state <= S_RDATA;
               end else begin
                  r_oe    <= 1'b0;
                  r_state <= r_after;
               end
            end
            S_RDATA: if (w_scl_rise) r_bcnt <= r_bcnt + 4'd1;
               else if (w_scl_fall) begin
                  if (r_bcnt == 4'd8) begin
                     r_oe      <= 1'b0;
                     r_ack_drv <= 1'b0;
                     r_state   <= S_RACK;
                  end else r_oe <= ~r_shift[3'd7 - r_bcnt[2:0]];
               end
            S_RACK: if (w_scl_rise) begin
               r_ptr <= r_ptr + AW'(1);
               if (w_sda) r_state <= S_IDLE;
               else r_ack_drv <= 1'b1;
            end else if (w_scl_fall && r_ack_drv) begin
               r_shift <= w_rd_byte;
               r_oe    <= ~w_rd_byte[7];
               r_bcnt  <= '0;
               r_state <= S_RDATA;
            end
            default: ;
         endcase
      end
   assign bus.sda_oe_o   = r_oe;
   assign bus.busy_o     = r_busy;
   assign bus.wr_valid_o = r_wr_valid;
   assign bus.wr_addr_o  = r_wr_addr;
   assign bus.wr_data_o  = r_wr_data;
   assign bus.rd_data_o  = r_regs[bus.rd_addr_i];
endmodule

// File: tb/tb_i2c_target_regfile.sv
// tb_i2c_target_regfile: bit-banged I2C host against a transaction-level register-file model
module tb_i2c_target_regfile;
   localparam int Q = 8;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic scl = 1'b1;
   logic sda_h = 1'b1;
   logic [3:0] rd_addr = '0;
   int n_tests = 0;
   int n_fail = 0;
   always #5 clk = ~clk;
   i2c_target_regfile_if #(.AW(4)) ifc();
   i2c_target_regfile #(.DevAddr(7'h50), .NumRegs(16), .FilterLen(3)) dut (
      .clk_i(clk), .rst_ni(rst_n), .bus(ifc)
   );
   assign ifc.scl_i     = scl;
   assign ifc.sda_i     = sda_h & ~ifc.sda_oe_o;
   assign ifc.rd_addr_i = rd_addr;
   logic [11:0] wr_q[$];
   logic [7:0]  txq[$];
   logic        oe_seen = 1'b0;
   logic [7:0]  m_regs [16];
   int          m_ptr = 0;
   always @(negedge clk) begin
      if (ifc.wr_valid_o) wr_q.push_back({ifc.wr_addr_o, ifc.wr_data_o});
      if (ifc.sda_oe_o) oe_seen = 1'b1;
   end
   initial begin
      repeat (90000) @(posedge clk);
      $display("FAIL watchdog: run did not end, tests=%0d", n_tests);
      $fatal(1);
   end
   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      n_tests++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, a, e);
      end
   endtask
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic clk_bit(input logic b, output logic l, output logic o);
      tick(Q); sda_h = b;
      tick(Q); scl = 1'b1;
      tick(Q); l = ifc.sda_i; o = ifc.sda_oe_o;
      tick(Q); scl = 1'b0;
   endtask
   task automatic i2c_start();
      tick(Q); sda_h = 1'b1;
      tick(Q); scl = 1'b1;
      tick(Q); sda_h = 1'b0;
      tick(Q); scl = 1'b0;
   endtask
   task automatic i2c_stop();
      tick(Q); sda_h = 1'b0;
      tick(Q); scl = 1'b1;
      tick(Q); sda_h = 1'b1;
      tick(Q);
   endtask
   // ACKed byte: line low and target driving during the 9th clock
   task automatic wr_byte(input logic [7:0] b, input string nm, input logic acked);
      logic l, o;
      for (int i = 7; i >= 0; i--) clk_bit(b[i], l, o);
      clk_bit(1'b1, l, o);
      chk({nm, " ack"}, {30'd0, l, o}, acked ? 32'd1 : 32'd2);
   endtask
   task automatic rd_byte(input logic nack, output logic [7:0] d);
      logic l, o;
      for (int i = 0; i < 8; i++) begin
         clk_bit(1'b1, l, o);
         d = {d[6:0], l};
      end
      clk_bit(nack, l, o);
   endtask
   task automatic do_write(input logic [7:0] p);
      logic [11:0] exp[$];
      wr_q.delete();
      i2c_start();
      wr_byte(8'hA0, "waddr", 1'b1);
      chk("busy after match", ifc.busy_o, 1);
      wr_byte(p, "ptr", 1'b1);
      foreach (txq[i]) wr_byte(txq[i], "wdata", 1'b1);
      i2c_stop();
      chk("busy after stop", ifc.busy_o, 0);
      m_ptr = p % 16;
      foreach (txq[i]) begin
         exp.push_back({m_ptr[3:0], txq[i]});
         m_regs[m_ptr] = txq[i];
         m_ptr = (m_ptr + 1) % 16;
      end
      chk("wr count", wr_q.size(), exp.size());
      foreach (exp[i]) if (i < wr_q.size()) chk("wr event", wr_q[i], exp[i]);
   endtask
   task automatic do_read(input logic [7:0] p, input int n, input logic set_ptr);
      logic [7:0] d;
      if (set_ptr) begin
         i2c_start();
         wr_byte(8'hA0, "waddr", 1'b1);
         wr_byte(p, "ptr", 1'b1);
         m_ptr = p % 16;
      end
      i2c_start();
      wr_byte(8'hA1, "raddr", 1'b1);
      for (int i = 0; i < n; i++) begin
         rd_byte(i == n - 1, d);
         chk("rdata", d, m_regs[m_ptr]);
         m_ptr = (m_ptr + 1) % 16;
      end
      tick(Q);
      chk("sda released after nack", ifc.sda_oe_o, 0);
      i2c_stop();
   endtask
   typedef struct {
      logic [7:0] ptr;
      logic [7:0] data;
      logic [3:0] idx;
   } vec_t;
   vec_t vt[5];
   initial begin
      logic l, o;
      vt[0] = '{8'h00, 8'h3C, 4'h0};
      vt[1] = '{8'h1F, 8'h81, 4'hF};
      vt[2] = '{8'hF7, 8'h7E, 4'h7};
      vt[3] = '{8'h8A, 8'hC9, 4'hA};
      vt[4] = '{8'h4C, 8'h06, 4'hC};
      foreach (m_regs[i]) m_regs[i] = 8'h00;
      #2 rst_n = 1'b0;
      tick(3);
      rd_addr = 4'd5;
      #1;
      chk("reset sda_oe", ifc.sda_oe_o, 0);
      chk("reset busy", ifc.busy_o, 0);
      chk("reset wr_valid", ifc.wr_valid_o, 0);
      chk("reset rd_data", ifc.rd_data_o, 0);
      rst_n = 1'b1;
      tick(4);
      // reg 5 preset so the pointer left after the burst read is visible
      txq = '{8'hC3};
      do_write(8'h05);
      txq = '{8'hA5, 8'h5A};
      do_write(8'h03);
      chk("burst ev0", wr_q[0], {4'd3, 8'hA5});
      chk("burst ev1", wr_q[1], {4'd4, 8'h5A});
      rd_addr = 4'd4;
      #1;
      chk("rd_data idx4", ifc.rd_data_o, 8'h5A);
      do_read(8'h03, 2, 1'b1);
      chk("pointer after read", m_ptr, 5);
      do_read(8'h00, 1, 1'b0);
      wr_q.delete();
      oe_seen = 1'b0;
      i2c_start();
      wr_byte(8'hA2, "mismatch", 1'b0);
      chk("mismatch busy", ifc.busy_o, 0);
      i2c_stop();
      chk("mismatch oe never", oe_seen, 0);
      chk("mismatch no write", wr_q.size(), 0);
      txq = '{8'h11, 8'h22};
      do_write(8'h1F);
      chk("wrap ev0", wr_q[0], {4'hF, 8'h11});
      chk("wrap ev1", wr_q[1], {4'h0, 8'h22});
      tick(Q); sda_h = 1'b0;
      tick(2); sda_h = 1'b1;
      tick(Q); scl = 1'b0;
      wr_byte(8'hA0, "glitch2", 1'b0);
      chk("glitch2 busy", ifc.busy_o, 0);
      i2c_stop();
      tick(Q); sda_h = 1'b0;
      tick(3); scl = 1'b0;
      wr_byte(8'hA0, "glitch3", 1'b1);
      chk("glitch3 busy", ifc.busy_o, 1);
      i2c_stop();
      foreach (vt[i]) begin
         txq = '{vt[i].data};
         do_write(vt[i].ptr);
         chk("tbl event", wr_q[0], {vt[i].idx, vt[i].data});
         rd_addr = vt[i].idx;
         #1;
         chk("tbl rd_data", ifc.rd_data_o, vt[i].data);
      end
      for (int t = 0; t < 12; t++) begin
         logic [7:0] p;
         int n;
         p = 8'($urandom_range(0, 255));
         n = $urandom_range(1, 4);
         if ($urandom_range(0, 1) == 1) begin
            txq.delete();
            for (int i = 0; i < n; i++) txq.push_back(8'($urandom));
            do_write(p);
         end else do_read(p, n, 1'b1);
      end
      for (int i = 0; i < 16; i++) begin
         rd_addr = 4'(i);
         #1;
         chk("reg dump", ifc.rd_data_o, m_regs[i]);
      end
      txq = '{8'hA5};
      do_write(8'h03);
      i2c_start();
      wr_byte(8'hA0, "waddr", 1'b1);
      wr_byte(8'h03, "ptr", 1'b1);
      i2c_start();
      wr_byte(8'hA1, "raddr", 1'b1);
      clk_bit(1'b1, l, o);
      chk("rst read bit7", l, 1);
      for (int i = 0; i < 20 && !ifc.sda_oe_o; i++) tick(1);
      chk("oe before reset", ifc.sda_oe_o, 1);
      rst_n = 1'b0;
      #1;
      chk("oe async clear", ifc.sda_oe_o, 0);
      rd_addr = 4'd3;
      #1;
      chk("regs cleared", ifc.rd_data_o, 0);
      foreach (m_regs[i]) m_regs[i] = 8'h00;
      m_ptr = 0;
      tick(2);
      rst_n = 1'b1;
      tick(4);
      i2c_stop();
      do_read(8'h03, 1, 1'b1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
